par_link_rx: RTL and testbench
==============================

Name: par_link_rx

Overview:
Parametrised successor to the byte-wide SPI-style slave interface feeding the TPU. It receives a source-clocked parallel bus (clk_in/sel_in/data_in) and synchronises it into the system clock domain. It packs BEATS bus beats into one word and buffers words in a DEPTH-entry FIFO with valid/ready backpressure. Unlike the single-byte slave it adds configurable bus width, beat packing order, framing error detection and overflow accounting.

Parameters:
BUS_WIDTH, 8, width of data_in per beat
BEATS, 2, beats packed per output word; WORD_WIDTH = BUS_WIDTH*BEATS
DEPTH, 16, FIFO depth in words; power of two, >=2
MSB_FIRST, 1, 1: first beat lands in the most significant slice; 0: least significant slice
SYNC_STAGES, 2, synchroniser flops on clk_in/sel_in/data_in; >=2
CNT_WIDTH, 16, width of the saturating drop counter

Ports:
clk  in  1  system clock; sole clock of the block
rst  in  1  reset, synchronous, active-high
clk_in  in  1  source strobe, asynchronous; data sampled on its rising edge
sel_in  in  1  frame select, active-high, asynchronous
data_in  in  BUS_WIDTH  beat data, stable around the clk_in rise
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head when out_valid & out_ready
out_data  out  WORD_WIDTH  FIFO head word
fifo_level  out  $clog2(DEPTH)+1  words stored
overflow  out  1  sticky: a word was dropped on a full FIFO
ovf_clr  in  1  clears overflow and drop_cnt
drop_cnt  out  CNT_WIDTH  saturating count of dropped words
frame_done  out  1  one-cycle pulse: sel fell on a word boundary
frame_err  out  1  one-cycle pulse: sel fell mid-word; partial word discarded
busy  out  1  synchronised sel_in

Behaviour:
- Reset (rst high at a clk edge): all outputs 0, FIFO empty, beat_cnt=0, sync flops 0, armed=0.
- Input timing contract: clk_in high and low >= SYNC_STAGES+1 clk periods each; data_in and sel_in stable from 1 clk before to SYNC_STAGES+1 clk after the clk_in rise.
- Sync: three signals pass through SYNC_STAGES flops (_s), plus one history flop (_h). rise = clk_s & ~clk_h; sel_fall = ~sel_s & sel_h.
- Arming: armed sets on the first cycle with sel_s=0 after reset. Edges are ignored while armed=0, so no spurious edge is taken from a pin held high through reset.
- Beat capture: on rise & sel_s & armed, data_s goes into slice beat_cnt (MSB_FIRST chooses the order) and beat_cnt increments. At beat_cnt==BEATS-1 the assembled word is pushed on that same edge and beat_cnt returns to 0.
- Latency: the word becomes visible on out_valid SYNC_STAGES+1 clk edges after the final clk_in rise is sampled by the first sync flop. There is no same-cycle fall-through.
- FIFO: pop = out_valid & out_ready. With push & pop both active, both succeed, including when full. With push on full and no pop, the word is dropped, overflow<=1 and drop_cnt increments, saturating at all-ones.
- ovf_clr: clears overflow and drop_cnt. If a drop occurs in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- Framing: on sel_fall with beat_cnt!=0, the partial word is discarded, beat_cnt<=0 and frame_err pulses. On sel_fall with beat_cnt==0, frame_done pulses. A rise coinciding with sel_fall is ignored, because sel_s is already 0.
- out_data holds the head word. Its value is don't-care when out_valid=0; the bench must not check it then.
- fifo_level is exact and updates the cycle after push/pop. Both pointers are $clog2(DEPTH) bits and wrap naturally.
- Reset mid-frame: the partial word and FIFO contents are lost, and no frame_err is produced.

Decomposition:
- Package par_link_pkg holds the WORD_WIDTH/level-width derivation helpers and the beat-index/level typedefs parameterised via localparams.
- Sub-module sync_fifo (WIDTH, DEPTH; push/pop/full/empty/level/rdata) is instantiated once.
- Synchroniser, edge detect, packer and framing logic stay in par_link_rx.

Test Plan:
- BEATS=2, MSB_FIRST=1: send beats 0xAB,0xCD in one frame -> out_data=0xABCD, out_valid after SYNC_STAGES+1 edges, frame_done pulses once on sel fall.
- MSB_FIRST=0, same beats -> out_data=0xCDAB.
- Three beats 0x11,0x22,0x33 then sel fall -> one word 0x1122, frame_err pulse, fifo_level=1; the 0x33 beat is dropped.
- out_ready=0, send 18 words with DEPTH=16 -> fifo_level=16, overflow=1, drop_cnt=2. Then pulse ovf_clr -> overflow=0, drop_cnt=0.
- FIFO full, one word push and out_ready=1 on the same cycle -> no drop, fifo_level stays 16, order preserved.
- clk_in held high across rst deassert, sel_in high -> no word captured until sel_in goes low then high. Also assert rst mid-word -> fifo_level=0 and no pulses.

Source files
------------

// File: rtl/par_link_pkg.sv
// Shared width helpers for the parallel link receiver and its word FIFO.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package par_link_pkg;

    localparam int BUS_WIDTH_DEF = 8;
    localparam int BEATS_DEF     = 2;
    localparam int DEPTH_DEF     = 16;

    function automatic int word_width(input int bus_w, input int beats);
        return bus_w * beats;
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // A single-beat word still needs a 1-bit counter to stay a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [idx_width(BEATS_DEF)-1:0]   beat_idx_t;
    typedef logic [level_width(DEPTH_DEF)-1:0] level_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO with an exact occupancy count and show-ahead head.
// Latency: a push is visible on empty/rdata the cycle after it is written.
// Backpressure: push on full is accepted only together with a pop.
module sync_fifo
    import par_link_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         rdata
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;
    logic             wr_ok;

    assign full   = (level == LVL_W'(DEPTH));
    assign empty  = (level == '0);
    assign pop_ok = pop & ~empty;
    assign wr_ok  = push & (~full | pop_ok);
    assign rdata  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/par_link_rx.sv
// Source-clocked parallel bus receiver: synchronise, pack beats into words, buffer.
// Latency: word on out_valid SYNC_STAGES+1 edges after its last strobe is first sampled.
// Backpressure: out_valid/out_ready; words arriving on a full FIFO are dropped and counted.
module par_link_rx
    import par_link_pkg::*;
#(
    parameter int BUS_WIDTH   = 8,
    parameter int BEATS       = 2,
    parameter int DEPTH       = 16,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_in,
    input  logic                         sel_in,
    input  logic [BUS_WIDTH-1:0]         data_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BUS_WIDTH*BEATS-1:0]   out_data,
    output logic [$clog2(DEPTH):0]       fifo_level,
    output logic                         overflow,
    input  logic                         ovf_clr,
    output logic [CNT_WIDTH-1:0]         drop_cnt,
    output logic                         frame_done,
    output logic                         frame_err,
    output logic                         busy
);
    localparam int WORD_WIDTH = word_width(BUS_WIDTH, BEATS);
    localparam int IDX_W      = idx_width(BEATS);
    localparam int FILL_W     = SYNC_STAGES + 1;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

    logic [SYNC_STAGES-1:0]                clk_sync;
    logic [SYNC_STAGES-1:0]                sel_sync;
    logic [SYNC_STAGES-1:0][BUS_WIDTH-1:0] data_sync;
    logic                                  clk_h;
    logic                                  sel_h;
    logic [FILL_W-1:0]                     fill;
    logic                                  armed;

    logic                  clk_s;
    logic                  sel_s;
    logic [BUS_WIDTH-1:0]  data_s;
    logic                  rise;
    logic                  sel_fall;
    logic                  capture;
    logic                  push_vld;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  drop;

    logic [IDX_W-1:0]      beat_cnt;
    logic [WORD_WIDTH-1:0] word_buf;
    logic [WORD_WIDTH-1:0] word_nxt;
    int                    slot;

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign sel_s    = sel_sync[SYNC_STAGES-1];
    assign data_s   = data_sync[SYNC_STAGES-1];
    assign rise     = clk_s & ~clk_h;
    assign sel_fall = ~sel_s & sel_h;
    assign busy     = sel_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '0;
            sel_sync  <= '0;
            data_sync <= '0;
            clk_h     <= 1'b0;
            sel_h     <= 1'b0;
            fill      <= '0;
            armed     <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], clk_in};
            sel_sync  <= {sel_sync[SYNC_STAGES-2:0], sel_in};
            data_sync <= {data_sync[SYNC_STAGES-2:0], data_in};
            clk_h     <= clk_s;
            sel_h     <= sel_s;
            fill      <= {fill[FILL_W-2:0], 1'b1};
            // Arm only once the sync and history flops hold real pin samples,
            // so a pin held high through reset never looks like a fresh edge.
            if (fill[FILL_W-1] && !sel_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign capture  = rise & sel_s & armed;
    assign push_vld = capture & (beat_cnt == LAST_BEAT);

    always_comb begin
        word_nxt = word_buf;
        slot     = MSB_FIRST ? (BEATS - 1 - int'(beat_cnt)) : int'(beat_cnt);
        word_nxt[slot*BUS_WIDTH +: BUS_WIDTH] = data_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt   <= '0;
            word_buf   <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (sel_fall && armed) begin
                beat_cnt <= '0;
                if (beat_cnt != '0) begin
                    frame_err <= 1'b1;
                end else begin
                    frame_done <= 1'b1;
                end
            end else if (capture) begin
                word_buf <= word_nxt;
                beat_cnt <= push_vld ? '0 : beat_cnt + 1'b1;
            end
        end
    end

    assign pop  = out_valid & out_ready;
    assign drop = push_vld & fifo_full & ~pop;

    // A drop in the same cycle as a clear is reported as the first new drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_clr) begin
                drop_cnt <= CNT_WIDTH'(1);
            end else if (!(&drop_cnt)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end else if (ovf_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    sync_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_vld),
        .push_dat (word_nxt),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level),
        .rdata    (out_data)
    );

    assign out_valid = ~fifo_empty;

endmodule

// File: tb/tb_par_link_rx.sv
// Directed bench for par_link_rx: two instances (MSB-first and LSB-first) share stimulus.
// Inputs change on the falling clock edge; outputs are sampled there as well.
module tb_par_link_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_in;
    logic        sel_in;
    logic [7:0]  data_in;
    logic        out_ready;
    logic        ovf_clr;

    logic        out_valid_m, out_valid_l;
    logic [15:0] out_data_m,  out_data_l;
    logic [4:0]  fifo_level_m, fifo_level_l;
    logic        overflow_m,  overflow_l;
    logic [15:0] drop_cnt_m,  drop_cnt_l;
    logic        frame_done_m, frame_done_l;
    logic        frame_err_m,  frame_err_l;
    logic        busy_m,       busy_l;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    par_link_rx #(.BUS_WIDTH(8), .BEATS(2), .DEPTH(16), .MSB_FIRST(1'b1),
                  .SYNC_STAGES(2), .CNT_WIDTH(16)) u_msb (
        .clk(clk), .rst(rst), .clk_in(clk_in), .sel_in(sel_in), .data_in(data_in),
        .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m),
        .fifo_level(fifo_level_m), .overflow(overflow_m), .ovf_clr(ovf_clr),
        .drop_cnt(drop_cnt_m), .frame_done(frame_done_m), .frame_err(frame_err_m),
        .busy(busy_m)
    );

    par_link_rx #(.BUS_WIDTH(8), .BEATS(2), .DEPTH(16), .MSB_FIRST(1'b0),
                  .SYNC_STAGES(2), .CNT_WIDTH(16)) u_lsb (
        .clk(clk), .rst(rst), .clk_in(clk_in), .sel_in(sel_in), .data_in(data_in),
        .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l),
        .fifo_level(fifo_level_l), .overflow(overflow_l), .ovf_clr(ovf_clr),
        .drop_cnt(drop_cnt_l), .frame_done(frame_done_l), .frame_err(frame_err_l),
        .busy(busy_l)
    );

    always @(negedge clk) begin
        if (frame_done_m) done_cnt++;
        if (frame_err_m)  err_cnt++;
    end

    task automatic send_beat(input logic [7:0] d);
        data_in = d;
        @(negedge clk);
        clk_in = 1'b1;
        repeat (4) @(negedge clk);
        clk_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic sel_on();
        sel_in = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic sel_off();
        sel_in = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_in = 1'b0; sel_in = 1'b0; data_in = 8'h00;
        out_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({out_valid_m, overflow_m, frame_done_m, frame_err_m, busy_m} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {out_valid_m, overflow_m, frame_done_m, frame_err_m, busy_m});
        end
        tests++;
        if (fifo_level_m !== 5'd0 || drop_cnt_m !== 16'd0) begin
            fails++;
            $display("FAIL reset_counts: level %0d drop %0d expected 0 0", fifo_level_m, drop_cnt_m);
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        tests++;
        if (out_valid_m !== 1'b0 || busy_m !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle: valid %b busy %b expected 0 0", out_valid_m, busy_m);
        end
    endtask

    task automatic test_latency_order();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        sel_on();
        tests++;
        if (busy_m !== 1'b1) begin
            fails++;
            $display("FAIL busy_high: got %b expected 1", busy_m);
        end
        send_beat(8'hAB);
        data_in = 8'hCD;
        @(negedge clk);
        clk_in = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid_m !== 1'b0) begin
            fails++;
            $display("FAIL latency_edge1: valid %b expected 0", out_valid_m);
        end
        @(negedge clk);
        tests++;
        if (out_valid_m !== 1'b0) begin
            fails++;
            $display("FAIL latency_edge2: valid %b expected 0", out_valid_m);
        end
        @(negedge clk);
        tests++;
        if (out_valid_m !== 1'b1 || fifo_level_m !== 5'd1) begin
            fails++;
            $display("FAIL latency_edge3: valid %b level %0d expected 1 1", out_valid_m, fifo_level_m);
        end
        tests++;
        if (out_data_m !== 16'hABCD) begin
            fails++;
            $display("FAIL msb_first_word: got %h expected abcd", out_data_m);
        end
        tests++;
        if (out_data_l !== 16'hCDAB) begin
            fails++;
            $display("FAIL lsb_first_word: got %h expected cdab", out_data_l);
        end
        clk_in = 1'b0;
        repeat (4) @(negedge clk);
        sel_off();
        tests++;
        if (done_cnt !== d0 + 1 || err_cnt !== e0) begin
            fails++;
            $display("FAIL frame_done_pulse: done %0d err %0d expected %0d %0d",
                     done_cnt - d0, err_cnt - e0, 1, 0);
        end
        pop_one();
        tests++;
        if (fifo_level_m !== 5'd0 || out_valid_m !== 1'b0) begin
            fails++;
            $display("FAIL pop_to_empty: level %0d valid %b expected 0 0", fifo_level_m, out_valid_m);
        end
    endtask

    task automatic test_frame_err();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        sel_on();
        send_beat(8'h11);
        send_beat(8'h22);
        send_beat(8'h33);
        sel_off();
        tests++;
        if (fifo_level_m !== 5'd1 || out_valid_m !== 1'b1) begin
            fails++;
            $display("FAIL err_level: level %0d valid %b expected 1 1", fifo_level_m, out_valid_m);
        end
        tests++;
        if (out_data_m !== 16'h1122) begin
            fails++;
            $display("FAIL err_word: got %h expected 1122", out_data_m);
        end
        tests++;
        if (err_cnt !== e0 + 1 || done_cnt !== d0) begin
            fails++;
            $display("FAIL frame_err_pulse: err %0d done %0d expected 1 0", err_cnt - e0, done_cnt - d0);
        end
        pop_one();
    endtask

    task automatic test_overflow();
        sel_on();
        for (int k = 0; k < 18; k++) begin
            send_beat(8'(2 * k));
            send_beat(8'(2 * k + 1));
        end
        tests++;
        if (fifo_level_m !== 5'd16 || overflow_m !== 1'b1 || drop_cnt_m !== 16'd2) begin
            fails++;
            $display("FAIL overflow_state: level %0d ovf %b drop %0d expected 16 1 2",
                     fifo_level_m, overflow_m, drop_cnt_m);
        end
        sel_off();
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        tests++;
        if (overflow_m !== 1'b0 || drop_cnt_m !== 16'd0 || fifo_level_m !== 5'd16) begin
            fails++;
            $display("FAIL ovf_clr: ovf %b drop %0d level %0d expected 0 0 16",
                     overflow_m, drop_cnt_m, fifo_level_m);
        end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] exp;
        sel_on();
        send_beat(8'hE0);
        data_in = 8'hE1;
        @(negedge clk);
        clk_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        tests++;
        if (out_data_m !== 16'h0001) begin
            fails++;
            $display("FAIL full_head: got %h expected 0001", out_data_m);
        end
        @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (fifo_level_m !== 5'd16 || overflow_m !== 1'b0 || drop_cnt_m !== 16'd0) begin
            fails++;
            $display("FAIL full_push_pop: level %0d ovf %b drop %0d expected 16 0 0",
                     fifo_level_m, overflow_m, drop_cnt_m);
        end
        clk_in = 1'b0;
        repeat (4) @(negedge clk);
        sel_off();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? {8'(2 * (i + 1)), 8'(2 * (i + 1) + 1)} : 16'hE0E1;
            tests++;
            if (out_valid_m !== 1'b1 || out_data_m !== exp) begin
                fails++;
                $display("FAIL drain_order[%0d]: valid %b data %h expected 1 %h",
                         i, out_valid_m, out_data_m, exp);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        tests++;
        if (fifo_level_m !== 5'd0 || out_valid_m !== 1'b0) begin
            fails++;
            $display("FAIL drain_empty: level %0d valid %b expected 0 0", fifo_level_m, out_valid_m);
        end
    endtask

    task automatic test_arming_and_reset();
        int d0, e0;
        rst = 1'b1; clk_in = 1'b1; sel_in = 1'b1; data_in = 8'h99;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        d0 = done_cnt; e0 = err_cnt;
        repeat (10) @(negedge clk);
        repeat (2) begin
            clk_in = 1'b0;
            repeat (4) @(negedge clk);
            clk_in = 1'b1;
            repeat (4) @(negedge clk);
        end
        clk_in = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if (fifo_level_m !== 5'd0 || busy_m !== 1'b1) begin
            fails++;
            $display("FAIL unarmed_capture: level %0d busy %b expected 0 1", fifo_level_m, busy_m);
        end
        sel_off();
        tests++;
        if (done_cnt !== d0 || err_cnt !== e0) begin
            fails++;
            $display("FAIL unarmed_pulses: done %0d err %0d expected 0 0", done_cnt - d0, err_cnt - e0);
        end
        sel_on();
        send_beat(8'h5A);
        send_beat(8'hA5);
        tests++;
        if (fifo_level_m !== 5'd1 || out_data_m !== 16'h5AA5) begin
            fails++;
            $display("FAIL armed_word: level %0d data %h expected 1 5aa5", fifo_level_m, out_data_m);
        end
        send_beat(8'h77);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tests++;
        if (fifo_level_m !== 5'd0 || out_valid_m !== 1'b0) begin
            fails++;
            $display("FAIL midword_reset: level %0d valid %b expected 0 0", fifo_level_m, out_valid_m);
        end
        d0 = done_cnt; e0 = err_cnt;
        repeat (10) @(negedge clk);
        sel_off();
        tests++;
        if (done_cnt !== d0 || err_cnt !== e0 || fifo_level_m !== 5'd0) begin
            fails++;
            $display("FAIL midword_reset_pulses: done %0d err %0d level %0d expected 0 0 0",
                     done_cnt - d0, err_cnt - e0, fifo_level_m);
        end
        sel_on();
        send_beat(8'h3C);
        send_beat(8'hC3);
        tests++;
        if (fifo_level_m !== 5'd1 || out_data_m !== 16'h3CC3) begin
            fails++;
            $display("FAIL rearm_word: level %0d data %h expected 1 3cc3", fifo_level_m, out_data_m);
        end
        sel_off();
        tests++;
        if (done_cnt !== d0 + 1 || err_cnt !== e0) begin
            fails++;
            $display("FAIL rearm_done: done %0d err %0d expected 1 0", done_cnt - d0, err_cnt - e0);
        end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_latency_order();
        test_frame_err();
        test_overflow();
        test_full_push_pop();
        test_arming_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
